// File: rtl/fetch_queue.sv
// fetch_queue: in-order buffer of {pc, instr} pairs between fetch and decode.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     : fetch-side handshake; in_pc/in_instr are the entry
//   flush                 : redirect; drop every buffered entry
//   out_valid/out_ready   : decode-side handshake; out_pc/out_instr show the head
//   count                 : number of occupied entries (0..DEPTH)
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign in_ready  = !reset && (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Head is read straight from storage; empty queue shows a NOP at pc 0.
  assign out_pc    = out_valid ? mem_q[rd_ptr_q].pc    : '0;
  assign out_instr = out_valid ? mem_q[rd_ptr_q].instr : NOP;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // A pop here has already been handed to decode; a push is dropped.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, checked every
// cycle against a queue-based reference model (the scoreboard).
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 0;
  logic            reset, in_valid, flush, out_ready;
  logic            in_ready, out_valid;
  logic [XLEN-1:0] in_pc, in_instr, out_pc, out_instr;
  logic [$clog2(DEPTH):0] count;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [XLEN-1:0] pc; logic [XLEN-1:0] instr; } ent_t;
  ent_t sb[$];          // expected contents, head at index 0
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   done   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
  endtask

  // Reference model: applies the cycle's transfer rules to the queue.
  always @(posedge clk) begin
    int  sz;
    bit  do_pop, do_push;
    ent_t e;
    sz = sb.size();
    if (reset) sb.delete();
    else begin
      do_pop  = (sz != 0) && out_ready;
      do_push = in_valid && (sz != DEPTH);
      if (do_pop) void'(sb.pop_front());
      if (flush) sb.delete();
      else if (do_push) begin
        e.pc = in_pc; e.instr = in_instr;
        sb.push_back(e);
      end
    end
  end

  // Monitor: compare DUT outputs to the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      chk("count", 64'(count), 64'(sb.size()));
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(!reset && sb.size() != DEPTH));
      if (sb.size() != 0) begin
        chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
        chk("out_instr", 64'(out_instr), 64'(sb[0].instr));
      end else begin
        chk("empty_pc", 64'(out_pc), 64'd0);
        chk("empty_instr", 64'(out_instr), 64'h13);
      end
    end
  end

  // Drive one cycle's inputs, then let the edge happen.
  task automatic step(input bit iv, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                      input bit ordy, input bit fl, input bit rst);
    in_valid = iv; in_pc = pc; in_instr = ins;
    out_ready = ordy; flush = fl; reset = rst;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 0; flush = 0; reset = 1;
    #1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    idle(1);
    // Push and hold
    for (int i = 0; i < 3; i++) step(1, 32'(4*i), 32'hA0 + 32'(i), 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 1, 0);
    // Full and drain; pc 0x10 must be refused while full
    for (int i = 0; i < 4; i++) step(1, 32'(4*i), 32'hB0 + 32'(i), 0, 0, 0);
    step(1, 32'h10, 32'hBF, 0, 0, 0);
    step(1, 32'h10, 32'hBF, 0, 0, 0);
    drain(5);
    // Push while full with a pop: push still refused
    for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(4*i), 32'hC0 + 32'(i), 0, 0, 0);
    step(1, 32'h200, 32'hCF, 1, 0, 0);
    drain(5);
    // Simultaneous push and pop at count=2
    step(1, 32'h0, 32'hD0, 0, 0, 0);
    step(1, 32'h4, 32'hD1, 0, 0, 0);
    step(1, 32'h8, 32'hD2, 1, 0, 0);
    drain(3);
    // Streaming wrap-around
    for (int i = 0; i < 10; i++) step(1, 32'(4*i), 32'hE0 + 32'(i), 1, 0, 0);
    drain(2);
    // Flush with same-cycle push (and a same-cycle pop)
    for (int i = 0; i < 3; i++) step(1, 32'(4*i), 32'hF0 + 32'(i), 0, 0, 0);
    step(1, 32'h40, 32'hF4, 0, 1, 0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 32'h80 + 32'(4*i), 32'h70 + 32'(i), 0, 0, 0);
    step(1, 32'h44, 32'hF5, 1, 1, 0);
    idle(1);
    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 32'(4*i), 32'h90 + 32'(i), 0, 0, 0);
    step(1, 32'h50, 32'h95, 1, 1, 1);
    idle(2);
    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
    idle(1);
    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
